// File: rtl/axi4_slv_sram_burst.sv
// Purpose: AXI4 full-slave behavioural SRAM with FIXED/INCR/WRAP bursts and SLVERR on length, size and range faults.
// Latency: AR handshake -> first R beat next cycle, then one beat per cycle; last W handshake -> B next cycle.
// Backpressure: R/B payload held while ready is low; one outstanding transaction per direction.
// Build option: AXI4_SLV_WRAP_BURST_EN enables WRAP windows and WRAP length checks; otherwise WRAP behaves as INCR.
module axi4_slv_sram_burst #(
    parameter int          DW   = 128,
    parameter int          AW   = 14,
    parameter int          IW   = 4,
    parameter logic [31:0] BASE = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_aw_valid,
    output logic            mem_aw_ready,
    input  logic [IW-1:0]   mem_aw_bits_id,
    input  logic [31:0]     mem_aw_bits_addr,
    input  logic [7:0]      mem_aw_bits_len,
    input  logic [2:0]      mem_aw_bits_size,
    input  logic [1:0]      mem_aw_bits_burst,
    input  logic            mem_w_valid,
    output logic            mem_w_ready,
    input  logic [DW-1:0]   mem_w_bits_data,
    input  logic [DW/8-1:0] mem_w_bits_strb,
    input  logic            mem_w_bits_last,
    output logic            mem_b_valid,
    input  logic            mem_b_ready,
    output logic [IW-1:0]   mem_b_bits_id,
    output logic [1:0]      mem_b_bits_resp,
    input  logic            mem_ar_valid,
    output logic            mem_ar_ready,
    input  logic [IW-1:0]   mem_ar_bits_id,
    input  logic [31:0]     mem_ar_bits_addr,
    input  logic [7:0]      mem_ar_bits_len,
    input  logic [2:0]      mem_ar_bits_size,
    input  logic [1:0]      mem_ar_bits_burst,
    output logic            mem_r_valid,
    input  logic            mem_r_ready,
    output logic [IW-1:0]   mem_r_bits_id,
    output logic [DW-1:0]   mem_r_bits_data,
    output logic [1:0]      mem_r_bits_resp,
    output logic            mem_r_bits_last
);
    localparam int DEPTH = 1 << AW;
    localparam int SB    = DW / 8;
    localparam int BL    = $clog2(SB);
`ifdef AXI4_SLV_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    logic [DW-1:0] ram [0:DEPTH-1];

    function automatic logic in_range(input logic [31:0] a);
        logic [63:0] off;
        off = {32'd0, a - BASE};
        return (a >= BASE) && ((off >> (AW + BL)) == 64'd0);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> BL;
        return off[AW-1:0];
    endfunction

    // Without the wrap option a WRAP request is stored as INCR, so stepping never wraps.
    function automatic logic [1:0] eff_burst(input logic [1:0] b);
        return (b == 2'b10 && !WRAP_EN) ? 2'b01 : b;
    endfunction

    function automatic logic cmd_bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return (int'(size) > BL) ||
               (WRAP_EN && burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] inc, mask;
        inc  = a + (32'd1 << size);
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    // ---------------- write engine ----------------
    wstate_t       w_state, w_next;
    logic [IW-1:0] w_id;
    logic [31:0]   w_addr;
    logic [7:0]    w_len, w_cnt;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic          w_bad, w_err, w_extra;
    logic [1:0]    b_resp;
    logic          aw_hs, w_hs, w_we, w_beat_err;

    assign aw_hs = mem_aw_valid && mem_aw_ready;
    assign w_hs  = mem_w_valid && mem_w_ready;
    assign w_we  = w_hs && !w_bad && !w_extra && in_range(w_addr);
    assign w_beat_err = w_bad || !in_range(w_addr) ||
                        (mem_w_bits_last && (w_extra || w_cnt != w_len));

    assign mem_b_bits_id   = w_id;
    assign mem_b_bits_resp = b_resp;

    // Write FSM state register.
    always_ff @(posedge clock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state and handshake outputs; all held low while in reset.
    always_comb begin
        w_next       = w_state;
        mem_aw_ready = 1'b0;
        mem_w_ready  = 1'b0;
        mem_b_valid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                mem_aw_ready = !reset;
                if (mem_aw_valid && !reset) w_next = W_DATA;
            end
            W_DATA: begin
                mem_w_ready = !reset;
                if (mem_w_valid && mem_w_bits_last) w_next = W_RESP;
            end
            W_RESP: begin
                mem_b_valid = !reset;
                if (mem_b_ready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write command capture, beat counting, sticky error tracking and B response.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0; w_size <= '0; w_burst <= '0;
            w_bad <= 1'b0; w_err <= 1'b0; w_extra <= 1'b0; b_resp <= 2'b00;
        end else begin
            if (aw_hs) begin
                w_id    <= mem_aw_bits_id;
                w_addr  <= mem_aw_bits_addr;
                w_len   <= mem_aw_bits_len;
                w_size  <= mem_aw_bits_size;
                w_burst <= eff_burst(mem_aw_bits_burst);
                w_bad   <= cmd_bad(mem_aw_bits_len, mem_aw_bits_size, mem_aw_bits_burst);
                w_cnt   <= '0;
                w_err   <= 1'b0;
                w_extra <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err | w_beat_err;
                // A non-last beat at or past len means every following beat is surplus.
                if (!mem_w_bits_last && w_cnt >= w_len) w_extra <= 1'b1;
                if (mem_w_bits_last) b_resp <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    // Byte-lane writes into the array; contents are never cleared by reset.
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < SB; i++) begin
                if (mem_w_bits_strb[i]) ram[word_idx(w_addr)][i*8 +: 8] <= mem_w_bits_data[i*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    rstate_t       r_state, r_next;
    logic [IW-1:0] r_id;
    logic [31:0]   r_addr, rd_addr;
    logic [7:0]    r_len, r_cnt;
    logic [2:0]    r_size;
    logic [1:0]    r_burst, r_resp;
    logic          r_bad, rd_bad, rd_ok;
    logic [DW-1:0] r_data, rd_word;
    logic          ar_hs, r_hs;

    assign ar_hs = mem_ar_valid && mem_ar_ready;
    assign r_hs  = mem_r_valid && mem_r_ready;

    assign mem_r_bits_id   = r_id;
    assign mem_r_bits_data = r_data;
    assign mem_r_bits_resp = r_resp;
    assign mem_r_bits_last = mem_r_valid && (r_cnt == r_len);

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_next       = r_state;
        mem_ar_ready = 1'b0;
        mem_r_valid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                mem_ar_ready = !reset;
                if (mem_ar_valid && !reset) r_next = R_DATA;
            end
            R_DATA: begin
                mem_r_valid = !reset;
                if (mem_r_ready && r_cnt == r_len) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Address and word of the next beat to present: the AR address on acceptance, else the stepped address.
    always_comb begin
        rd_addr = next_addr(r_addr, r_size, r_len, r_burst);
        rd_bad  = r_bad;
        if (ar_hs) begin
            rd_addr = mem_ar_bits_addr;
            rd_bad  = cmd_bad(mem_ar_bits_len, mem_ar_bits_size, mem_ar_bits_burst);
        end
        rd_ok   = !rd_bad && in_range(rd_addr);
        rd_word = rd_ok ? ram[word_idx(rd_addr)] : '0;
    end

    // Read beat registers; sampling the array at the clock edge gives pre-write data on a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0;
            r_bad <= 1'b0; r_data <= '0; r_resp <= 2'b00;
        end else if (ar_hs) begin
            r_id    <= mem_ar_bits_id;
            r_addr  <= rd_addr;
            r_len   <= mem_ar_bits_len;
            r_size  <= mem_ar_bits_size;
            r_burst <= eff_burst(mem_ar_bits_burst);
            r_bad   <= rd_bad;
            r_cnt   <= '0;
            r_data  <= rd_word;
            r_resp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (r_hs && !mem_r_bits_last) begin
            r_addr <= rd_addr;
            r_cnt  <= r_cnt + 8'd1;
            r_data <= rd_word;
            r_resp <= rd_ok ? 2'b00 : 2'b10;
        end
    end
endmodule

// File: tb/tb_axi4_slv_sram_burst.sv
// Directed bench for axi4_slv_sram_burst: reset, INCR/WRAP reads, writes, length and range faults, concurrency, reset mid-burst.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed pattern words {16{byte}}.
module tb_axi4_slv_sram_burst;
    localparam int          DW   = 128;
    localparam int          IW   = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic            clock, reset;
    logic            aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [IW-1:0]   aw_id, b_id, ar_id, r_id;
    logic [31:0]     aw_addr, ar_addr;
    logic [7:0]      aw_len, ar_len;
    logic [2:0]      aw_size, ar_size;
    logic [1:0]      aw_burst, ar_burst, b_resp, r_resp;
    logic [DW-1:0]   w_data, r_data;
    logic [DW/8-1:0] w_strb;
    logic            ar_valid, ar_ready, r_valid, r_ready, r_last;

    int n_cmp = 0;
    int n_bad = 0;

    axi4_slv_sram_burst #(.DW(DW), .AW(14), .IW(IW), .BASE(BASE)) dut (
        .clock(clock), .reset(reset),
        .mem_aw_valid(aw_valid), .mem_aw_ready(aw_ready), .mem_aw_bits_id(aw_id),
        .mem_aw_bits_addr(aw_addr), .mem_aw_bits_len(aw_len), .mem_aw_bits_size(aw_size),
        .mem_aw_bits_burst(aw_burst),
        .mem_w_valid(w_valid), .mem_w_ready(w_ready), .mem_w_bits_data(w_data),
        .mem_w_bits_strb(w_strb), .mem_w_bits_last(w_last),
        .mem_b_valid(b_valid), .mem_b_ready(b_ready), .mem_b_bits_id(b_id), .mem_b_bits_resp(b_resp),
        .mem_ar_valid(ar_valid), .mem_ar_ready(ar_ready), .mem_ar_bits_id(ar_id),
        .mem_ar_bits_addr(ar_addr), .mem_ar_bits_len(ar_len), .mem_ar_bits_size(ar_size),
        .mem_ar_bits_burst(ar_burst),
        .mem_r_valid(r_valid), .mem_r_ready(r_ready), .mem_r_bits_id(r_id),
        .mem_r_bits_data(r_data), .mem_r_bits_resp(r_resp), .mem_r_bits_last(r_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int guard;
        ar_valid = 1'b1; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_id = id;
        guard = 0;
        while (!ar_ready && guard < 20) begin tick(); guard++; end
        if (!ar_ready) chk("ar_timeout", 0, 1);
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int guard;
        aw_valid = 1'b1; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_id = id;
        guard = 0;
        while (!aw_ready && guard < 20) begin tick(); guard++; end
        if (!aw_ready) chk("aw_timeout", 0, 1);
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d, input logic [15:0] st, input logic l);
        int guard;
        w_valid = 1'b1; w_data = d; w_strb = st; w_last = l;
        guard = 0;
        while (!w_ready && guard < 20) begin tick(); guard++; end
        if (!w_ready) chk("w_timeout", 0, 1);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic get_r(input string tag, input logic [127:0] d, input logic [1:0] rs,
                         input logic l, input logic [3:0] id);
        chk({tag, "_rvalid"}, r_valid, 1);
        chk({tag, "_rdata"}, r_data, d);
        chk({tag, "_rresp"}, r_resp, rs);
        chk({tag, "_rlast"}, r_last, l);
        chk({tag, "_rid"}, r_id, id);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic get_b(input string tag, input logic [1:0] rs, input logic [3:0] id);
        chk({tag, "_bvalid"}, b_valid, 1);
        chk({tag, "_bresp"}, b_resp, rs);
        chk({tag, "_bid"}, b_id, id);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order [4];
        reset = 1'b1;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
        tick(); tick();
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_last", r_last, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_aw_ready", aw_ready, 1);
        chk("post_rst_ar_ready", ar_ready, 1);

        // Single-beat INCR read of preloaded word 0, beat visible the cycle after AR.
        dut.ram[0] = pat(8'h11);
        send_ar(BASE, 8'd0, 3'd4, 2'b01, 4'd3);
        get_r("t1", pat(8'h11), 2'b00, 1'b1, 4'd3);

        // Four-beat INCR write, then read back with r_ready toggling.
        send_aw(BASE + 32'h40, 8'd3, 3'd4, 2'b01, 4'd5);
        for (int k = 0; k < 4; k++) send_w(pat(8'hA0 + 8'(k)), 16'hFFFF, k == 3);
        get_b("t2w", 2'b00, 4'd5);
        send_ar(BASE + 32'h40, 8'd3, 3'd4, 2'b01, 4'd6);
        for (int k = 0; k < 4; k++) begin
            chk("t2_pre", r_data, pat(8'hA0 + 8'(k)));
            tick();
            chk("t2_hold", r_data, pat(8'hA0 + 8'(k)));
            chk("t2_hold_vld", r_valid, 1);
            chk("t2_last", r_last, k == 3);
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
        end
        chk("t2_done", r_valid, 0);

        // WRAP read starting at word 3 of a 64-byte window.
        for (int i = 0; i < 7; i++) dut.ram[i] = pat(8'h30 + 8'(i));
`ifdef AXI4_SLV_WRAP_BURST_EN
        order = '{3, 0, 1, 2};
`else
        order = '{3, 4, 5, 6};
`endif
        send_ar(BASE + 32'h30, 8'd3, 3'd4, 2'b10, 4'd1);
        for (int k = 0; k < 4; k++) get_r("t3", pat(8'h30 + 8'(order[k])), 2'b00, k == 3, 4'd1);

        // Write len=3 terminated after two beats; first beat uses low-half strobes.
        for (int i = 16; i < 20; i++) dut.ram[i] = '0;
        send_aw(BASE + 32'h100, 8'd3, 3'd4, 2'b01, 4'd2);
        send_w(pat(8'hC1), 16'h00FF, 1'b0);
        send_w(pat(8'hC2), 16'hFFFF, 1'b1);
        get_b("t4", 2'b10, 4'd2);
        chk("t4_w16", dut.ram[16], {64'd0, {8{8'hC1}}});
        chk("t4_w17", dut.ram[17], pat(8'hC2));
        chk("t4_w18", dut.ram[18], 128'd0);

        // Out-of-range reads and write; the aliasing word 0 must stay untouched.
        send_ar(BASE - 32'd16, 8'd0, 3'd4, 2'b01, 4'd4);
        get_r("t5lo", 128'd0, 2'b10, 1'b1, 4'd4);
        send_ar(BASE + 32'h4_0000, 8'd0, 3'd4, 2'b01, 4'd4);
        get_r("t5hi", 128'd0, 2'b10, 1'b1, 4'd4);
        send_aw(BASE + 32'h4_0000, 8'd0, 3'd4, 2'b01, 4'd7);
        send_w(pat(8'hEE), 16'hFFFF, 1'b1);
        get_b("t5w", 2'b10, 4'd7);
        chk("t5_ram0", dut.ram[0], pat(8'h30));

        // Oversized beat size: SLVERR with zero data.
        send_ar(BASE, 8'd0, 3'd5, 2'b01, 4'd9);
        get_r("t5sz", 128'd0, 2'b10, 1'b1, 4'd9);

        // Read accepted in the same cycle as the write beat to that word returns the old value.
        dut.ram[8] = pat(8'h55);
        send_aw(BASE + 32'h80, 8'd0, 3'd4, 2'b01, 4'd1);
        ar_valid = 1'b1; ar_addr = BASE + 32'h80; ar_len = 0; ar_size = 3'd4; ar_burst = 2'b01; ar_id = 4'd8;
        w_valid = 1'b1; w_data = pat(8'h66); w_strb = 16'hFFFF; w_last = 1'b1;
        chk("t6_both_ready", {ar_ready, w_ready}, 2'b11);
        tick();
        ar_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
        get_r("t6_old", pat(8'h55), 2'b00, 1'b1, 4'd8);
        get_b("t6w", 2'b00, 4'd1);
        send_ar(BASE + 32'h80, 8'd0, 3'd4, 2'b01, 4'd8);
        get_r("t6_new", pat(8'h66), 2'b00, 1'b1, 4'd8);

        // Reset while a read burst is stalled.
        send_ar(BASE, 8'd3, 3'd4, 2'b01, 4'd2);
        chk("t7_rvalid_pre", r_valid, 1);
        reset = 1'b1;
        tick();
        chk("t7_rvalid_rst", r_valid, 0);
        reset = 1'b0;
        tick();
        chk("t7_ar_ready", ar_ready, 1);
        chk("t7_rvalid_after", r_valid, 0);
        chk("t7_ram_kept", dut.ram[17], pat(8'hC2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
